ca_code_gen: RTL and testbench

GPS L1 C/A code generator with programmable code-phase alignment.
- Sits downstream of the UART register bank. Consumes its enable, satellite-number, C/A phase-start and 16-bit C/A phase outputs.
- Produces one C/A code sample per clock (16 samples per chip at 16.368 MHz) for the modulator.
- Returns `code_phase_done_out` to the register bank, where it appears as status bit 0.

---
 rtl/ca_code_gen_if.sv | 21 ++
 rtl/ca_code_gen.sv | 218 +++++++++++++++++++++
 tb/tb_ca_code_gen.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/ca_code_gen_if.sv
// Control and sample bundle between the register bank, the C/A generator and the modulator.
interface ca_code_gen_if;
  logic        enable_in;
  logic [4:0]  n_sat_in;
  logic        ca_phase_start_in;
  logic [15:0] ca_phase_in;
  logic        ca_chip_out;
  logic        chip_tick_out;
  logic        epoch_out;
  logic        code_phase_done_out;

  modport master (
    output enable_in, n_sat_in, ca_phase_start_in, ca_phase_in,
    input  ca_chip_out, chip_tick_out, epoch_out, code_phase_done_out
  );

  modport slave (
    input  enable_in, n_sat_in, ca_phase_start_in, ca_phase_in,
    output ca_chip_out, chip_tick_out, epoch_out, code_phase_done_out
  );
endinterface

// File: rtl/ca_code_gen.sv
// GPS L1 C/A code generator (G1/G2 Gold code, one sample per clock) with code-phase alignment.
// Define CA_FAST_SLEW_EN to slew one chip per clock during alignment; otherwise one sample per clock.
module ca_code_gen #(
  parameter int SAMPLES_PER_CHIP = 16,
  parameter int CODE_LEN         = 1023
) (
  input logic          clk_in,
  input logic          rst_in_n,
  ca_code_gen_if.slave ca_if
);
  localparam int SW          = $clog2(SAMPLES_PER_CHIP);
  localparam int CW          = $clog2(CODE_LEN);
  localparam int PHASE_LIMIT = CODE_LEN * SAMPLES_PER_CHIP;
  localparam logic [SW-1:0] SAMP_LAST = SW'(SAMPLES_PER_CHIP - 1);
  localparam logic [CW-1:0] CHIP_LAST = CW'(CODE_LEN - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ALIGN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic          start_q;
  logic [SW-1:0] samp_q, samp_d;
  logic [CW-1:0] chip_q, chip_d;
  logic [9:0]    g1_q, g1_d;
  logic [9:0]    g2_q, g2_d;
  logic [CW-1:0] tgt_chip_q, tgt_chip_d;
  logic [SW-1:0] tgt_samp_q, tgt_samp_d;
  logic          done_q, done_d;
  logic          chip_o_q, chip_o_d;
  logic          tick_q, tick_d;
  logic          epoch_q, epoch_d;

  logic          start_edge;
  logic          phase_ok;
  logic          realign;
  logic          at_target;
  logic          run_d;
  logic [9:0]    g1_step, g2_step, g2_mask;
  logic [CW-1:0] chip_adv;
  logic [9:0]    g1_adv, g2_adv;

  function automatic logic [9:0] taps(input int a, input int b);
    return (10'd1 << (a - 1)) | (10'd1 << (b - 1));
  endfunction

  assign start_edge = ca_if.ca_phase_start_in & ~start_q;
  assign phase_ok   = {16'd0, ca_if.ca_phase_in} < 32'(PHASE_LIMIT);
  assign realign    = start_edge && phase_ok && (state_q != IDLE);

  // Bit i holds LFSR stage i+1; new bits enter stage 1 and the output is stage 10.
  assign g1_step = {g1_q[8:0], g1_q[2] ^ g1_q[9]};
  assign g2_step = {g2_q[8:0], g2_q[1] ^ g2_q[2] ^ g2_q[5] ^ g2_q[7] ^ g2_q[8] ^ g2_q[9]};

  assign chip_adv = (chip_q == CHIP_LAST) ? '0 : chip_q + CW'(1);
  assign g1_adv   = (chip_q == CHIP_LAST) ? '1 : g1_step;
  assign g2_adv   = (chip_q == CHIP_LAST) ? '1 : g2_step;

`ifdef CA_FAST_SLEW_EN
  assign at_target = (chip_q == tgt_chip_q);
`else
  assign at_target = (chip_q == tgt_chip_q) && (samp_q == tgt_samp_q);
`endif

  always_comb begin
    g2_mask = taps(4, 9);
    case (ca_if.n_sat_in)
      5'd0:  g2_mask = taps(2, 6);
      5'd1:  g2_mask = taps(3, 7);
      5'd2:  g2_mask = taps(4, 8);
      5'd3:  g2_mask = taps(5, 9);
      5'd4:  g2_mask = taps(1, 9);
      5'd5:  g2_mask = taps(2, 10);
      5'd6:  g2_mask = taps(1, 8);
      5'd7:  g2_mask = taps(2, 9);
      5'd8:  g2_mask = taps(3, 10);
      5'd9:  g2_mask = taps(2, 3);
      5'd10: g2_mask = taps(3, 4);
      5'd11: g2_mask = taps(5, 6);
      5'd12: g2_mask = taps(6, 7);
      5'd13: g2_mask = taps(7, 8);
      5'd14: g2_mask = taps(8, 9);
      5'd15: g2_mask = taps(9, 10);
      5'd16: g2_mask = taps(1, 4);
      5'd17: g2_mask = taps(2, 5);
      5'd18: g2_mask = taps(3, 6);
      5'd19: g2_mask = taps(4, 7);
      5'd20: g2_mask = taps(5, 8);
      5'd21: g2_mask = taps(6, 9);
      5'd22: g2_mask = taps(1, 3);
      5'd23: g2_mask = taps(4, 6);
      5'd24: g2_mask = taps(5, 7);
      5'd25: g2_mask = taps(6, 8);
      5'd26: g2_mask = taps(7, 9);
      5'd27: g2_mask = taps(8, 10);
      5'd28: g2_mask = taps(1, 6);
      5'd29: g2_mask = taps(2, 7);
      5'd30: g2_mask = taps(3, 8);
      5'd31: g2_mask = taps(4, 9);
      default: g2_mask = taps(4, 9);
    endcase
  end

  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    chip_d     = chip_q;
    g1_d       = g1_q;
    g2_d       = g2_q;
    tgt_chip_d = tgt_chip_q;
    tgt_samp_d = tgt_samp_q;
    done_d     = done_q;

    case (state_q)
      IDLE: begin
        samp_d  = '0;
        chip_d  = '0;
        g1_d    = '1;
        g2_d    = '1;
        done_d  = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        samp_d = samp_q + SW'(1);
        if (samp_q == SAMP_LAST) begin
          chip_d = chip_adv;
          g1_d   = g1_adv;
          g2_d   = g2_adv;
        end
      end
      ALIGN: begin
        if (at_target) begin
          samp_d  = tgt_samp_q;
          done_d  = 1'b1;
          state_d = RUN;
        end else begin
`ifdef CA_FAST_SLEW_EN
          chip_d = chip_adv;
          g1_d   = g1_adv;
          g2_d   = g2_adv;
`else
          samp_d = samp_q + SW'(1);
          if (samp_q == SAMP_LAST) begin
            chip_d = chip_adv;
            g1_d   = g1_adv;
            g2_d   = g2_adv;
          end
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    // A fresh in-range edge restarts alignment from phase 0, also while already aligning.
    if (realign) begin
      tgt_chip_d = CW'(ca_if.ca_phase_in >> SW);
      tgt_samp_d = ca_if.ca_phase_in[SW-1:0];
      samp_d     = '0;
      chip_d     = '0;
      g1_d       = '1;
      g2_d       = '1;
      done_d     = 1'b0;
      state_d    = ALIGN;
    end

    if (!ca_if.enable_in) begin
      samp_d  = '0;
      chip_d  = '0;
      g1_d    = '1;
      g2_d    = '1;
      done_d  = 1'b0;
      state_d = IDLE;
    end
  end

  // Outputs are registered from the next position so the first RUN cycle already shows it.
  assign run_d    = (state_d == RUN);
  assign chip_o_d = run_d & (g1_d[9] ^ (^(g2_d & g2_mask)));
  assign tick_d   = run_d && (samp_d == '0);
  assign epoch_d  = tick_d && (chip_d == '0);

  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q    <= IDLE;
      start_q    <= 1'b0;
      samp_q     <= '0;
      chip_q     <= '0;
      g1_q       <= '1;
      g2_q       <= '1;
      tgt_chip_q <= '0;
      tgt_samp_q <= '0;
      done_q     <= 1'b0;
      chip_o_q   <= 1'b0;
      tick_q     <= 1'b0;
      epoch_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      start_q    <= ca_if.ca_phase_start_in;
      samp_q     <= samp_d;
      chip_q     <= chip_d;
      g1_q       <= g1_d;
      g2_q       <= g2_d;
      tgt_chip_q <= tgt_chip_d;
      tgt_samp_q <= tgt_samp_d;
      done_q     <= done_d;
      chip_o_q   <= chip_o_d;
      tick_q     <= tick_d;
      epoch_q    <= epoch_d;
    end
  end

  assign ca_if.ca_chip_out         = chip_o_q;
  assign ca_if.chip_tick_out       = tick_q;
  assign ca_if.epoch_out           = epoch_q;
  assign ca_if.code_phase_done_out = done_q;
endmodule

// File: tb/tb_ca_code_gen.sv
// Directed bench for ca_code_gen: golden G1/G2 sequence model feeding a per-cycle scoreboard.
module tb_ca_code_gen;
  localparam int SPC    = 16;
  localparam int NCHIP  = 1023;
  localparam int PERIOD = SPC * NCHIP;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ca_code_gen_if ca_if ();

  ca_code_gen #(
    .SAMPLES_PER_CHIP(SPC),
    .CODE_LEN        (NCHIP)
  ) dut (
    .clk_in  (clk),
    .rst_in_n(rst_n),
    .ca_if   (ca_if)
  );

  always #5 clk = ~clk;

  bit g1seq[NCHIP];
  bit g2seq[NCHIP];
  int tap_a[32] = '{2, 3, 4, 5, 1, 2, 1, 2, 3, 2, 3, 5, 6, 7, 8, 9,
                    1, 2, 3, 4, 5, 6, 1, 4, 5, 6, 7, 8, 1, 2, 3, 4};
  int tap_b[32] = '{6, 7, 8, 9, 9, 10, 8, 9, 10, 3, 4, 6, 7, 8, 9, 10,
                    4, 5, 6, 7, 8, 9, 3, 6, 7, 8, 9, 10, 6, 7, 8, 9};

  logic [3:0] sb[$];
  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  bit m_run = 1'b0;
  bit m_done = 1'b0;
  int pos = 0;
  int prn = 0;
  logic [9:0] cap;

  // Stage k at chip n equals the stage-10 output seen (10-k) chips later.
  function automatic bit model(input int p, input int position);
    int n;
    n = position / SPC;
    return g1seq[n] ^ g2seq[(n + 10 - tap_a[p]) % NCHIP] ^ g2seq[(n + 10 - tap_b[p]) % NCHIP];
  endfunction

  function automatic logic [3:0] expected();
    if (m_run) return {model(prn, pos), (pos % SPC) == 0, pos == 0, m_done};
    return {3'b000, m_done};
  endfunction

  function automatic int align_len(input int target);
`ifdef CA_FAST_SLEW_EN
    return target / SPC + 1;
`else
    return target + 1;
`endif
  endfunction

  task automatic compare_pop(input string tag);
    logic [3:0] got;
    logic [3:0] want;
    got  = {ca_if.ca_chip_out, ca_if.chip_tick_out, ca_if.epoch_out, ca_if.code_phase_done_out};
    want = sb.pop_front();
    n_total++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s pos=%0d prn=%0d got(chip,tick,epoch,done)=%b want=%b", tag, pos, prn + 1, got, want);
    end
    if (m_run && (pos % SPC) == SPC / 2 && pos < 10 * SPC) cap[9 - pos / SPC] = got[3];
  endtask

  task automatic check_now(input string tag);
    sb.push_back(expected());
    compare_pop(tag);
  endtask

  task automatic step(input string tag);
    sb.push_back(expected());
    @(posedge clk);
    #1;
    compare_pop(tag);
    if (m_run) pos = (pos + 1) % PERIOD;
  endtask

  task automatic check_vec(input string tag, input logic [9:0] got, input logic [9:0] want);
    n_total++;
    assert (got === want) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s got=%o want=%o", tag, got, want);
    end
  endtask

  task automatic do_align(input int target);
    ca_if.ca_phase_start_in = 1'b1;
    ca_if.ca_phase_in       = 16'(target);
    m_run  = 1'b0;
    m_done = 1'b0;
    for (int i = 0; i < align_len(target); i++) begin
      step("align_hold");
      ca_if.ca_phase_start_in = 1'b0;
    end
    m_run  = 1'b1;
    m_done = 1'b1;
    pos    = target;
    step("align_first_run");
  endtask

  initial begin
    bit s1[1:10];
    bit s2[1:10];
    bit f1, f2;
    for (int k = 1; k <= 10; k++) begin
      s1[k] = 1'b1;
      s2[k] = 1'b1;
    end
    for (int n = 0; n < NCHIP; n++) begin
      g1seq[n] = s1[10];
      g2seq[n] = s2[10];
      f1 = s1[3] ^ s1[10];
      f2 = s2[2] ^ s2[3] ^ s2[6] ^ s2[8] ^ s2[9] ^ s2[10];
      for (int k = 10; k >= 2; k--) begin
        s1[k] = s1[k-1];
        s2[k] = s2[k-1];
      end
      s1[1] = f1;
      s2[1] = f2;
    end

    ca_if.enable_in         = 1'b0;
    ca_if.n_sat_in          = 5'd0;
    ca_if.ca_phase_start_in = 1'b0;
    ca_if.ca_phase_in       = 16'd0;

    #2;
    check_now("reset");
    @(posedge clk);
    #1;
    check_now("reset_hold");
    rst_n = 1'b1;
    repeat (3) step("idle");

    ca_if.ca_phase_start_in = 1'b1;
    ca_if.ca_phase_in       = 16'd16;
    step("start_while_disabled");
    ca_if.ca_phase_start_in = 1'b0;
    step("idle_after_start");

    // Enable and start rise together: enable wins, code starts at phase 0.
    ca_if.enable_in         = 1'b1;
    ca_if.ca_phase_start_in = 1'b1;
    m_run = 1'b1;
    pos   = 0;
    prn   = 0;
    cap   = '0;
    for (int i = 0; i <= PERIOD; i++) begin
      step("prn1_period");
      ca_if.ca_phase_start_in = 1'b0;
    end
    check_vec("prn1_first10", cap, 10'o1440);

    for (int i = 0; i < 2048; i++) begin
      ca_if.n_sat_in = 5'($urandom_range(0, 31));
      prn = int'(ca_if.n_sat_in);
      step("random_prn");
    end

    ca_if.enable_in = 1'b0;
    m_run = 1'b0;
    step("disable");
    step("idle_again");
    ca_if.enable_in = 1'b1;
    ca_if.n_sat_in  = 5'd1;
    prn   = 1;
    m_run = 1'b1;
    pos   = 0;
    cap   = '0;
    repeat (10 * SPC) step("prn2_start");
    check_vec("prn2_first10", cap, 10'o1620);

    ca_if.n_sat_in = 5'd0;
    prn = 0;
    repeat (5) step("prn1_run");

    do_align(16);
    repeat (PERIOD - 16) step("after_align16");

    do_align(PERIOD - 1);
    step("epoch_after_16367");
    repeat (3) step("run_after_16367");

    ca_if.ca_phase_start_in = 1'b1;
    ca_if.ca_phase_in       = 16'(PERIOD);
    step("ignore_16368");
    ca_if.ca_phase_start_in = 1'b0;
    step("continuity");
    ca_if.ca_phase_start_in = 1'b1;
    ca_if.ca_phase_in       = 16'hFFFF;
    step("ignore_ffff");
    ca_if.ca_phase_start_in = 1'b0;
    repeat (3) step("continuity");

    ca_if.ca_phase_start_in = 1'b1;
    ca_if.ca_phase_in       = 16'd5000;
    m_run  = 1'b0;
    m_done = 1'b0;
    step("align_5000");
    ca_if.ca_phase_start_in = 1'b0;
    repeat (3) step("align_5000_wait");
    ca_if.enable_in = 1'b0;
    step("disable_mid_align");
    step("idle_mid");
    ca_if.enable_in = 1'b1;
    m_run = 1'b1;
    pos   = 0;
    repeat (20) step("rerun_from_zero");

    ca_if.ca_phase_start_in = 1'b1;
    ca_if.ca_phase_in       = 16'd8000;
    m_run  = 1'b0;
    m_done = 1'b0;
    step("align_8000");
    ca_if.ca_phase_start_in = 1'b0;
    repeat (2) step("align_8000_wait");
    do_align(32);
    repeat (20) step("after_align32");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
